// File: rtl/bp_pkg.sv
// Shared constants and the 2-bit saturating counter helper for the branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] JUMP_JALR  = 2'b11;

    // Saturating step of a 2-bit direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken) return (c == ST)  ? ST  : c + 2'd1;
        else       return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped tagged branch target buffer: async read/tag compare, one write port.
module btb
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] rd_pc_i,
    output logic        rd_hit_o,
    output logic        rd_jump_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [31:2] wr_pc_i,
    input  logic [31:0] wr_target_i,
    input  logic        wr_jump_i
);

    localparam int TAG_W   = 30 - IDX_BITS;
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic               jump_q   [ENTRIES];

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]    rd_tag, wr_tag;

    assign rd_idx = rd_pc_i[IDX_BITS+1:2];
    assign rd_tag = rd_pc_i[31:IDX_BITS+2];
    assign wr_idx = wr_pc_i[IDX_BITS+1:2];
    assign wr_tag = wr_pc_i[31:IDX_BITS+2];

    // Lookup reads registered state only, so a same-cycle write is not visible yet.
    always_comb begin
        rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_jump_o   = jump_q[rd_idx];
        rd_target_o = target_q[rd_idx];
    end

    // A write always allocates; any previous owner of the slot is simply replaced.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) valid_d[wr_idx] = 1'b1;
    end

    // Valid bits are the only state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Payload storage; stale contents are masked by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target_i;
            jump_q[wr_idx]   <= wr_jump_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// gshare branch predictor: GHR ^ PC indexes 2-bit counters, plus a tagged BTB.
// Prediction is combinational; training happens at MEM resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BTB_IDX_BITS = 4,
    parameter int GHR_BITS     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         if_pc,
    output logic                pred_hit,
    output logic                pred_dir,
    output logic [31:0]         pred_next_pc,
    output logic [GHR_BITS-1:0] pred_bht_idx,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_is_branch,
    input  logic [1:0]          upd_jump,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_bht_idx
);

    localparam int BHT_N = 1 << GHR_BITS;

    logic [BHT_N-1:0][1:0]  bht_q, bht_d;
    logic [GHR_BITS-1:0]    ghr_q, ghr_d;

    logic        btb_hit, btb_jump;
    logic [31:0] btb_target;
    logic        jmp_upd, br_upd, btb_wr;

    // jal and jalr train identically (jalr simply overwrites the target), and
    // PCs are word aligned, so these bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{upd_jump[0], upd_pc[1:0]};

    // A jump code wins over the branch flag if both were ever set together.
    assign jmp_upd = upd_valid && upd_jump[1];
    assign br_upd  = upd_valid && upd_is_branch && !upd_jump[1];
    assign btb_wr  = jmp_upd || (br_upd && upd_taken);

    btb #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_pc_i     (if_pc[31:2]),
        .rd_hit_o    (btb_hit),
        .rd_jump_o   (btb_jump),
        .rd_target_o (btb_target),
        .wr_en_i     (btb_wr),
        .wr_pc_i     (upd_pc[31:2]),
        .wr_target_i (upd_target),
        .wr_jump_i   (jmp_upd)
    );

    // IF-stage prediction from current (pre-update) state.
    always_comb begin
        pred_bht_idx = ghr_q ^ if_pc[GHR_BITS+1:2];
        pred_hit     = btb_hit;
        pred_dir     = (btb_hit && btb_jump) || bht_q[pred_bht_idx][1];
        pred_next_pc = (pred_hit && pred_dir) ? btb_target : if_pc + 32'd4;
    end

    // Only resolved conditional branches move the counters and the history.
    always_comb begin
        bht_d = bht_q;
        ghr_d = ghr_q;
        if (br_upd) begin
            bht_d[upd_bht_idx] = ctr_next(bht_q[upd_bht_idx], upd_taken);
            ghr_d              = {ghr_q[GHR_BITS-2:0], upd_taken};
        end
    end

    // Reset to weakly not-taken with empty history; reset beats any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            bht_q <= {BHT_N{WNT}};
            ghr_q <= '0;
        end else begin
            bht_q <= bht_d;
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors, hand-computed predictions.
module tb_branch_predictor;
    import bp_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        dir;
        logic [31:0] nxt;
        logic [4:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_hit, pred_dir;
    logic [31:0] pred_next_pc;
    logic [4:0]  pred_bht_idx;
    logic        upd_valid, upd_is_branch, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic [1:0]  upd_jump;
    logic [4:0]  upd_bht_idx;

    exp_t sb[$];
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.BTB_IDX_BITS(4), .GHR_BITS(5)) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_dir(pred_dir), .pred_next_pc(pred_next_pc),
        .pred_bht_idx(pred_bht_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_jump(upd_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_bht_idx(upd_bht_idx)
    );

    // Monitor: whenever a probe is presented, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL probe pc=%h: no expectation queued", if_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pred_hit !== e.hit || pred_dir !== e.dir ||
                    pred_next_pc !== e.nxt || pred_bht_idx !== e.idx || if_pc !== e.pc) begin
                    errors++;
                    $display("FAIL pred pc=%h: got hit=%b dir=%b next=%h idx=%h, want hit=%b dir=%b next=%h idx=%h",
                             if_pc, pred_hit, pred_dir, pred_next_pc, pred_bht_idx,
                             e.hit, e.dir, e.nxt, e.idx);
                end
            end
        end
    end

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic [1:0] jmp,
                           input logic tk, input logic [31:0] tgt, input logic [4:0] idx);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_is_branch = br;
        upd_jump      = jmp;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_bht_idx   = idx;
    endtask

    // One cycle: present if_pc (and any pending update), optionally queue an expectation.
    task automatic cyc(input logic [31:0] pc, input logic chk, input logic eh, input logic ed,
                       input logic [31:0] en, input logic [4:0] ei);
        exp_t e;
        if_pc = pc;
        if (chk) begin
            e.pc = pc; e.hit = eh; e.dir = ed; e.nxt = en; e.idx = ei;
            sb.push_back(e);
        end
        chk_en = chk;
        @(posedge clk);
        #1;
        chk_en    = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic probe(input logic [31:0] pc, input logic eh, input logic ed,
                         input logic [31:0] en, input logic [4:0] ei);
        cyc(pc, 1'b1, eh, ed, en, ei);
    endtask

    task automatic idle();
        cyc(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'h0);
    endtask

    initial begin
        reset = 1'b1; if_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_is_branch = 1'b0; upd_jump = 2'b00;
        upd_taken = 1'b0; upd_target = 32'h0; upd_bht_idx = 5'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state, including next-PC wrap at the top of the address space.
        probe(32'h100,      1'b0, 1'b0, 32'h104,      5'h00);
        probe(32'hFFFFFFFC, 1'b0, 1'b0, 32'h00000000, 5'h1F);

        // First taken update of 0x100: same-cycle probe sees old state.
        set_upd(32'h100, 1'b1, 2'b00, 1'b1, 32'h80, 5'h1F);
        probe(32'h100, 1'b0, 1'b0, 32'h104, 5'h00);
        // GHR=00001, BHT[1]=01: entry hits but predicts not taken.
        probe(32'h100, 1'b1, 1'b0, 32'h104, 5'h01);
        for (int i = 0; i < 4; i++) begin
            set_upd(32'h100, 1'b1, 2'b00, 1'b1, 32'h80, 5'h1F);
            idle();
        end
        // GHR=11111, BHT[1F] saturated at 11.
        probe(32'h100, 1'b1, 1'b1, 32'h80,  5'h1F);
        probe(32'h104, 1'b0, 1'b0, 32'h108, 5'h1E);

        // Not-taken #1: BHT[1F]=10, GHR=11110; 0x104 maps to idx 1F, dir from MSB without hit.
        set_upd(32'h100, 1'b1, 2'b00, 1'b0, 32'h80, 5'h1F);
        idle();
        probe(32'h104, 1'b0, 1'b1, 32'h108, 5'h1F);
        for (int i = 0; i < 3; i++) begin
            set_upd(32'h100, 1'b1, 2'b00, 1'b0, 32'h80, 5'h1F);
            idle();
        end
        // GHR=10000, BHT[1F]=00 (no wrap), BTB entry for 0x100 still valid.
        probe(32'h100, 1'b1, 1'b0, 32'h104, 5'h10);
        probe(32'h03C, 1'b0, 1'b0, 32'h040, 5'h1F);

        // jalr at 0x200 twice (same BTB slot as 0x100); second target wins.
        set_upd(32'h200, 1'b0, JUMP_JALR, 1'b1, 32'h300, 5'h03);
        idle();
        set_upd(32'h200, 1'b0, JUMP_JALR, 1'b1, 32'h400, 5'h03);
        idle();
        probe(32'h200, 1'b1, 1'b1, 32'h400, 5'h10);
        probe(32'h03C, 1'b0, 1'b0, 32'h040, 5'h1F);
        probe(32'h100, 1'b0, 1'b0, 32'h104, 5'h10);

        // upd_valid with neither branch nor jump must change nothing.
        set_upd(32'h500, 1'b0, 2'b00, 1'b1, 32'h600, 5'h1F);
        idle();
        probe(32'h500, 1'b0, 1'b0, 32'h504, 5'h10);
        probe(32'h200, 1'b1, 1'b1, 32'h400, 5'h10);
        probe(32'h03C, 1'b0, 1'b0, 32'h040, 5'h1F);

        // jal at 0x204.
        set_upd(32'h204, 1'b0, 2'b10, 1'b1, 32'h1000, 5'h00);
        idle();
        probe(32'h204, 1'b1, 1'b1, 32'h1000, 5'h11);

        // Conflict: 0x100 then 0x140 share BTB slot 0.
        set_upd(32'h100, 1'b1, 2'b00, 1'b1, 32'h80, 5'h00);  // BHT[0]=10, GHR=00001
        idle();
        probe(32'h100, 1'b1, 1'b0, 32'h104, 5'h01);
        set_upd(32'h140, 1'b1, 2'b00, 1'b1, 32'h180, 5'h00); // BHT[0]=11, GHR=00011
        idle();
        probe(32'h100, 1'b0, 1'b0, 32'h104, 5'h03);
        probe(32'h140, 1'b1, 1'b0, 32'h144, 5'h13);
        probe(32'h00C, 1'b0, 1'b1, 32'h010, 5'h00);

        // Reset with a concurrent taken update: everything cleared, update dropped.
        reset = 1'b1;
        set_upd(32'h00C, 1'b1, 2'b00, 1'b1, 32'h900, 5'h00);
        idle();
        reset = 1'b0;
        probe(32'h00C, 1'b0, 1'b0, 32'h010, 5'h03);
        probe(32'h204, 1'b0, 1'b0, 32'h208, 5'h01);
        probe(32'h000, 1'b0, 1'b0, 32'h004, 5'h00);
        probe(32'h140, 1'b0, 1'b0, 32'h144, 5'h10);

        // Drain: every queued expectation must have been consumed by the monitor.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RV32I pipeline. It produces the IF-stage prediction (BTB hit, predicted direction, predicted next PC) that travels down the pipeline and reaches the hazard unit as the MEM-stage hit/pred bits. It is trained by the MEM-stage resolution of that same branch or jump, which closes the loop with the flush decision. Organisation is gshare: a global history register XORed with PC bits indexes a table of 2-bit counters, plus a direct-mapped, tagged BTB.

## Interface
Parameters:
- BTB_IDX_BITS, 4, log2 of BTB entries (16)
- GHR_BITS, 5, history length; the BHT has 2^GHR_BITS counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_pc  in  32  PC being fetched
- pred_hit  out  1  BTB valid and tag match for if_pc
- pred_dir  out  1  predicted taken: BTB entry is a jump, or BHT counter MSB
- pred_next_pc  out  32  (pred_hit & pred_dir) ? BTB target : if_pc+4
- pred_bht_idx  out  GHR_BITS  BHT index used; carried down the pipeline
- upd_valid  in  1  MEM-stage resolution valid this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_is_branch  in  1  conditional branch (opcode 1100011)
- upd_jump  in  2  jump code as carried in the pipe; [1]=jump, 2'b11=jalr
- upd_taken  in  1  actual branch outcome
- upd_target  in  32  actual target address
- upd_bht_idx  in  GHR_BITS  pred_bht_idx returned from MEM

## Operation
- Prediction is combinational from if_pc and current state.
  - BTB index = if_pc[BTB_IDX_BITS+1:2]; tag = if_pc[31:BTB_IDX_BITS+2].
  - BHT index = GHR ^ if_pc[GHR_BITS+1:2].
- BTB entry fields: valid, tag, target[31:0], is_jump.
- The update applies only when upd_valid=1 and either upd_is_branch or upd_jump[1] is set; otherwise there is no state change.
- Conditional branch update:
  - BHT[upd_bht_idx] saturates: taken increments toward 2'b11, not-taken decrements toward 2'b00.
  - GHR = {GHR[GHR_BITS-2:0], upd_taken}.
  - If taken, write the BTB entry: valid=1, tag, target, is_jump=0.
  - If not taken, the BTB is untouched and no entry is allocated.
- Jump update (upd_jump[1]=1):
  - Write the BTB entry: valid=1, tag, target, is_jump=1. For jalr this always overwrites the target.
  - BHT and GHR are untouched.
- A tag conflict replaces the existing entry (direct-mapped, no LRU).
- GHR is non-speculative: it is updated only at MEM resolution. Flushed wrong-path instructions never reach upd_valid, so no rollback is needed.

## Timing
- Prediction has zero latency. The outputs are valid in the same cycle as if_pc.
- Updates commit at the rising clk edge where upd_valid=1.
- Read-during-write: a prediction in the update cycle sees pre-update state. The new state is visible from the next cycle.
- Reset (synchronous, takes precedence over updates):
  - all BTB valid=0;
  - every BHT counter=2'b01 (weakly not-taken);
  - GHR=0.
- Output values after reset: pred_hit=0, pred_dir=0, pred_next_pc=if_pc+4, pred_bht_idx=if_pc[GHR_BITS+1:2].
- Reset asserted mid-training discards all state in that cycle. A concurrent upd_valid is ignored.
- pred_next_pc uses 32-bit addition; it wraps at 0xFFFFFFFC+4 = 0x00000000.

## Structure
- Shared package bp_pkg:
  - counter constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - OPC_BRANCH=7'b1100011;
  - JUMP_JALR=2'b11.
- Sub-module btb: BTB storage, tag compare, and write port.
- The BHT, GHR, and counter saturation logic stay in branch_predictor.

## Test plan
- Reset, then if_pc=0x100 -> pred_hit=0, pred_dir=0, pred_next_pc=0x104.
- Five taken updates from reset, each with upd_pc=0x100, upd_target=0x80, upd_bht_idx=0x1F:
  - BHT[0x1F] goes 01→10→11 and saturates at 11;
  - GHR ends at 5'b11111;
  - then if_pc=0x100 -> pred_bht_idx=0x1F, pred_hit=1, pred_dir=1, pred_next_pc=0x80.
- Saturation down: continuing the previous scenario, four not-taken updates at idx 0x1F give 11→10→01→00→00.
  - GHR ends at 5'b10000.
  - BTB entry stays valid and not-taken updates do not clear it.
- jalr retarget:
  - update upd_pc=0x200, upd_jump=2'b11, target 0x300, then again with target 0x400;
  - if_pc=0x200 -> hit=1, dir=1, next_pc=0x400;
  - BHT and GHR are unchanged.
- Same-cycle read/write and conflict:
  - if_pc=0x100 while the first taken update of 0x100 commits -> hit=0 that cycle, hit=1 the next cycle;
  - a later taken update of 0x140 (same index, different tag) -> if_pc=0x100 gives hit=0.
- Reset mid-operation: pulse reset with upd_valid=1 -> all BTB entries invalid, all counters 01, GHR=0, and the update is dropped.
